// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst reader: FSM state encoding and
// default data/address widths used by the reader top and its buffer.
package ram_pkg;

   localparam int RAM_D_WIDTH = 16;
   localparam int RAM_A_WIDTH = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Small output buffer for the burst reader. Each entry holds one RAM word
// plus its last-beat flag. The head entry is read straight from the
// register storage, so a word written at one edge is visible as
// o_rd_valid/o_rd_data in the very next cycle. Depth need not be a power
// of two; pointers wrap explicitly at DEPTH-1.
module ram_rd_fifo
   import ram_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = RAM_D_WIDTH + 1,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_ready,
   output logic             o_rd_valid,
   output logic [WIDTH-1:0] o_rd_data,
   output logic [CW-1:0]    o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_rd_valid = (r_count != '0);
   assign w_pop      = o_rd_valid & i_rd_ready;
   // The writer never overfills, but a full buffer still refuses a push.
   assign w_push     = i_wr_en & (r_count != CW'(DEPTH));
   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_count    = r_count;

   // Storage: cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for the dual-port RAM. Issues one read address per
// cycle, tracks the two-cycle registered read latency with a valid/last
// pipe, and buffers returned words into a valid/ready stream.
// Reads are only issued while buffered plus in-flight words fit in the
// buffer, so backpressure never loses data.
// Optional: define RAM_READER_PERF_EN to add the stall_cycles counter port.
module ram_burst_reader
   import ram_pkg::*;
#(
   parameter int D_WIDTH    = RAM_D_WIDTH,
   parameter int A_WIDTH    = RAM_A_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [A_WIDTH-1:0] base_addr,
   input  logic [A_WIDTH:0]   burst_len,
   output logic               busy,
   output logic               done,
`ifdef RAM_READER_PERF_EN
   output logic [15:0]        stall_cycles,
`endif
   output logic [A_WIDTH-1:0] address_read,
   input  logic [D_WIDTH-1:0] data_read,
   output logic [D_WIDTH-1:0] m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_last
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = CW + 1;
   localparam logic [A_WIDTH:0] LEN_ONE = {{A_WIDTH{1'b0}}, 1'b1};

   rd_state_t          r_state;
   rd_state_t          w_state_next;

   logic [A_WIDTH-1:0] r_addr;
   logic [A_WIDTH:0]   r_issue_cnt;
   logic [A_WIDTH:0]   r_len;
   logic               r_pv0;
   logic               r_pv1;
   logic               r_pl0;
   logic               r_pl1;
   logic               r_done;

   logic               w_accept;
   logic               w_first_issue;
   logic               w_issue;
   logic               w_issue_any;
   logic               w_issue_last;
   logic               w_done_next;
   logic               w_pop;
   logic               w_head_last;
   logic               w_room;
   logic [1:0]         w_inflight;
   logic [OW-1:0]      w_occupancy;
   logic [A_WIDTH:0]   w_cnt_inc;

   logic               w_fifo_valid;
   logic [D_WIDTH:0]   w_fifo_data;
   logic [CW-1:0]      w_fifo_count;

   // Words issued but not yet captured: stage 0 = address registered,
   // stage 1 = RAM has registered the data.
   assign w_inflight  = {1'b0, r_pv0} + {1'b0, r_pv1};
   assign w_occupancy = OW'(w_fifo_count) + OW'(w_inflight);
   assign w_room      = (w_occupancy < OW'(FIFO_DEPTH));
   assign w_cnt_inc   = r_issue_cnt + LEN_ONE;
   assign w_pop       = w_fifo_valid & m_ready;
   assign w_head_last = w_fifo_data[D_WIDTH];

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state: leave ISSUE once the final read is out, leave DRAIN
   // when the final beat is handed over.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (start && (burst_len != '0)) begin
               w_state_next = (burst_len == LEN_ONE) ? DRAIN : ISSUE;
            end
         end
         ISSUE: begin
            if (w_issue && w_issue_last) begin
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (w_pop && w_head_last) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs: issue strobes and done request decoded from the state.
   always_comb begin
      w_accept      = (r_state == IDLE) & start;
      w_first_issue = w_accept & (burst_len != '0);
      w_issue       = (r_state == ISSUE) & w_room;
      w_issue_any   = w_first_issue | w_issue;
      w_issue_last  = w_first_issue ? (burst_len == LEN_ONE) : (w_cnt_inc == r_len);
      w_done_next   = (w_accept & (burst_len == '0)) |
                      ((r_state == DRAIN) & w_pop & w_head_last);
   end

   // Address/issue counter, latency pipe and the registered done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_issue_cnt <= '0;
         r_len       <= '0;
         r_pv0       <= 1'b0;
         r_pv1       <= 1'b0;
         r_pl0       <= 1'b0;
         r_pl1       <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_first_issue) begin
            r_addr      <= base_addr;
            r_issue_cnt <= LEN_ONE;
            r_len       <= burst_len;
         end else if (w_issue) begin
            // Natural wrap of the address width gives modulo addressing.
            r_addr      <= r_addr + 1'b1;
            r_issue_cnt <= w_cnt_inc;
         end
         r_pv0  <= w_issue_any;
         r_pl0  <= w_issue_any & w_issue_last;
         r_pv1  <= r_pv0;
         r_pl1  <= r_pl0;
         r_done <= w_done_next;
      end
   end

   ram_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (D_WIDTH + 1),
      .CW    (CW)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (r_pv1),
      .i_wr_data  ({r_pl1, data_read}),
      .i_rd_ready (m_ready),
      .o_rd_valid (w_fifo_valid),
      .o_rd_data  (w_fifo_data),
      .o_count    (w_fifo_count)
   );

   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign address_read = r_addr;
   assign m_valid      = w_fifo_valid;
   assign m_data       = w_fifo_data[D_WIDTH-1:0];
   assign m_last       = w_fifo_valid & w_fifo_data[D_WIDTH];

`ifdef RAM_READER_PERF_EN
   logic [15:0] r_stall;

   // Saturating count of cycles where a ready beat is held off by the sink.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall <= '0;
      end else if (w_accept) begin
         r_stall <= '0;
      end else if (busy && w_fifo_valid && !m_ready && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 1'b1;
      end
   end

   assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: burst timing, address wrap,
// backpressure with stalls, zero-length and ignored starts, async reset
// mid-burst, and (when RAM_READER_PERF_EN is defined) the stall counter.
module tb_ram_burst_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  base_addr;
   logic [5:0]  burst_len;
   logic        busy;
   logic        done;
   logic [4:0]  address_read;
   logic [15:0] data_read;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
`ifdef RAM_READER_PERF_EN
   logic [15:0] stall_cycles;
`endif

   logic [15:0] mem [32];

   int n_cmp = 0;
   int n_bad = 0;

   int          beat;
   logic        saw_done;
   logic        prev_hold;
   logic [15:0] prev_data;

   logic [15:0] exp1  [4] = '{16'hA003, 16'hA004, 16'hA005, 16'hA006};
   logic [4:0]  exp2a [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
   logic [15:0] exp2d [4] = '{16'hA01E, 16'hA01F, 16'hA000, 16'hA001};
   logic [15:0] exp3  [8] = '{16'hA008, 16'hA009, 16'hA00A, 16'hA00B,
                              16'hA00C, 16'hA00D, 16'hA00E, 16'hA00F};

   ram_burst_reader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .base_addr    (base_addr),
      .burst_len    (burst_len),
      .busy         (busy),
      .done         (done),
`ifdef RAM_READER_PERF_EN
      .stall_cycles (stall_cycles),
`endif
      .address_read (address_read),
      .data_read    (data_read),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_last       (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM read port model: one-cycle registered read.
   always @(posedge clk) data_read <= mem[address_read];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
      rst_n = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0; m_ready = 1'b0;

      // ---- reset state
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_data", m_data, 0);
      chk("rst_addr", address_read, 0);
      #20;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // ---- test 1: base=3 len=4, sink always ready
      start = 1'b1; base_addr = 5'd3; burst_len = 6'd4; m_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t1_busy", busy, 1);
      chk("t1_addr_c1", address_read, 3);
      chk("t1_valid_c1", m_valid, 0);
      @(negedge clk);
      chk("t1_valid_c2", m_valid, 0);
      chk("t1_addr_c2", address_read, 4);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t1_valid", m_valid, 1);
         chk("t1_data", m_data, exp1[k]);
         chk("t1_last", m_last, (k == 3));
         chk("t1_done_low", done, 0);
      end
      @(negedge clk);
      chk("t1_done", done, 1);
      chk("t1_busy_end", busy, 0);
      chk("t1_valid_end", m_valid, 0);
      chk("t1_addr_hold", address_read, 6);
      @(negedge clk);
      chk("t1_done_one_cycle", done, 0);

      // ---- test 2: address wrap, base=30 len=4
      start = 1'b1; base_addr = 5'd30; burst_len = 6'd4; m_ready = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk); start = 1'b0;
         if (k <= 4) chk("t2_addr", address_read, exp2a[k-1]);
         if (k >= 3 && k <= 6) begin
            chk("t2_valid", m_valid, 1);
            chk("t2_data", m_data, exp2d[k-3]);
            chk("t2_last", m_last, (k == 6));
         end
         if (k == 7) chk("t2_done", done, 1);
      end
      @(negedge clk);

      // ---- test 3: backpressure, base=8 len=8
      start = 1'b1; base_addr = 5'd8; burst_len = 6'd8; m_ready = 1'b0;
      beat = 0; saw_done = 1'b0; prev_hold = 1'b0; prev_data = '0;
      for (int c = 1; c < 80; c++) begin
         @(negedge clk); start = 1'b0;
         if (c >= 3 && c <= 6) m_ready = (c % 2 == 0);
         else if (c >= 7 && c <= 16) m_ready = 1'b0;
         else m_ready = 1'b1;
         if (prev_hold) begin
            chk("t3_hold_valid", m_valid, 1);
            chk("t3_hold_data", m_data, prev_data);
         end
         if (c == 16) begin
            chk("t3_issue_stalled_addr", address_read, 13);
            chk("t3_stall_head", m_data, 16'hA00A);
         end
         if (done) begin
            saw_done = 1'b1;
            break;
         end
         if (m_valid && m_ready) begin
            if (beat < 8) begin
               chk("t3_data", m_data, exp3[beat]);
               chk("t3_last", m_last, (beat == 7));
            end else begin
               chk("t3_extra_beat", beat, 7);
            end
            beat++;
         end
         prev_hold = m_valid && !m_ready;
         prev_data = m_data;
      end
      chk("t3_beat_count", beat, 8);
      chk("t3_done_seen", saw_done, 1);

      // ---- test 4: len=0 requested in the done cycle of the previous burst
      start = 1'b1; base_addr = 5'd0; burst_len = 6'd0;
      @(negedge clk); start = 1'b0;
      chk("t4_zero_done", done, 1);
      chk("t4_zero_busy", busy, 0);
      chk("t4_zero_valid", m_valid, 0);
      @(negedge clk);
      chk("t4_zero_done_end", done, 0);
      chk("t4_zero_busy_end", busy, 0);

      // start held while busy must be ignored
      start = 1'b1; base_addr = 5'd0; burst_len = 6'd3; m_ready = 1'b1;
      @(negedge clk);
      base_addr = 5'd20; burst_len = 6'd5;
      chk("t4_busy", busy, 1);
      @(negedge clk);
      chk("t4_addr", address_read, 1);
      @(negedge clk);
      chk("t4_d0", m_data, 16'hA000);
      chk("t4_v0", m_valid, 1);
      @(negedge clk); start = 1'b0;
      chk("t4_d1", m_data, 16'hA001);
      chk("t4_l1", m_last, 0);
      @(negedge clk);
      chk("t4_d2", m_data, 16'hA002);
      chk("t4_l2", m_last, 1);
      @(negedge clk);
      chk("t4_done", done, 1);
      chk("t4_addr_end", address_read, 2);
      @(negedge clk);

      // ---- test 5: async reset mid-burst
      start = 1'b1; base_addr = 5'd16; burst_len = 6'd8; m_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_b0", m_data, 16'hA010);
      @(negedge clk);
      chk("t5_b1", m_data, 16'hA011);
      @(negedge clk);
      chk("t5_pre_valid", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", m_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_data", m_data, 0);
      chk("t5_rst_last", m_last, 0);
      chk("t5_rst_addr", address_read, 0);
      @(negedge clk);
      chk("t5_no_done_a", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_done_b", done, 0);
      chk("t5_idle_valid", m_valid, 0);
      start = 1'b1; base_addr = 5'd5; burst_len = 6'd2;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_n0", m_data, 16'hA005);
      chk("t5_n0_last", m_last, 0);
      @(negedge clk);
      chk("t5_n1", m_data, 16'hA006);
      chk("t5_n1_last", m_last, 1);
      @(negedge clk);
      chk("t5_done", done, 1);
      @(negedge clk);

`ifdef RAM_READER_PERF_EN
      // ---- test 6: stall counter, five held cycles with a beat waiting
      start = 1'b1; base_addr = 5'd0; burst_len = 6'd4; m_ready = 1'b1;
      beat = 0; saw_done = 1'b0;
      for (int c = 1; c < 40; c++) begin
         @(negedge clk); start = 1'b0;
         m_ready = !(c >= 3 && c <= 7);
         if (done) begin
            saw_done = 1'b1;
            chk("t6_stall_cycles", stall_cycles, 5);
            break;
         end
         if (m_valid && m_ready) beat++;
      end
      chk("t6_beats", beat, 4);
      chk("t6_done_seen", saw_done, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
Read-side initiator for the dual-port RAM. It takes a burst request (base address and length) and drives the RAM read port one address per cycle. It absorbs the RAM's registered read latency and presents the returned words as a valid/ready stream with a last-beat marker and full backpressure. It sits between RAM consumers (DMA, packet egress) and the RAM read port.

Parameters:
D_WIDTH, 16, RAM data word width
A_WIDTH, 5, RAM address width; memory depth 2**A_WIDTH
FIFO_DEPTH, 4, output buffer entries; legal range 3..16 (power of two not required)

Ports:
clk  input  1  single clock; also drives the RAM clk_read
rst_n  input  1  asynchronous active-low reset
start  input  1  burst request strobe; sampled only when busy=0
base_addr  input  A_WIDTH  first RAM address of the burst
burst_len  input  A_WIDTH+1  number of words, 0..2**A_WIDTH
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion
address_read  output  A_WIDTH  registered address to the RAM read port
data_read  input  D_WIDTH  RAM read data; valid one clk after address_read is sampled
m_data  output  D_WIDTH  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready
m_last  output  1  marks the final beat of the burst

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, m_valid=0, m_last=0, m_data=0, address_read=0; FIFO, in-flight pipe and counters are cleared.
- Reset asserted mid-burst aborts the burst immediately. No done pulse is produced, and any words already buffered are discarded.
- States: IDLE, ISSUE, DRAIN.
- IDLE, start=1, burst_len>0: address_read<=base_addr, issue count=1, go to ISSUE (or to DRAIN if burst_len=1). busy=1 from the next cycle.
- IDLE, start=1, burst_len=0: no reads are issued; done=1 for one cycle on the next cycle; busy stays 0.
- start is ignored while busy=1.
- Issue rule: a read is issued in a cycle only when fifo_count + inflight < FIFO_DEPTH. Here inflight is the number of issued reads whose data has not yet been captured (0..2).
- Each issue increments address_read modulo 2**A_WIDTH. Wrap past the top address to 0 is legal and required.
- Capture pipeline: an issue at edge E is captured into the FIFO at edge E+2, when the RAM has registered data_read.
- First m_valid appears 2 cycles after the start cycle.
- When no read is issued, address_read holds its value. The RAM still reads that address, but the result is discarded (tracked by a valid bit in the pipe).
- ISSUE to DRAIN: after the burst_len-th read is issued.
- DRAIN to IDLE: when the last beat completes its handshake (m_valid & m_ready & m_last). done=1 and busy=0 in the following cycle.
- The next start is accepted in the same cycle as that done pulse.
- Stream rules:
  - Beats are in address order.
  - m_data, m_last and m_valid are stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_last=1 only on beat burst_len.
- Throughput: with m_ready held at 1, one beat per cycle and no bubbles after the first.
- FIFO full: issuing stalls; no data is lost.
- FIFO empty: m_valid=0.
- Capture and pop in the same cycle keeps the count unchanged.

Optional Feature:
RAM_READER_PERF_EN
- Defined: adds output port stall_cycles [15:0]. It counts cycles with busy=1 and m_valid=1 and m_ready=0, saturates at 16'hFFFF, clears on accepted start and on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package ram_pkg: state enum (IDLE/ISSUE/DRAIN) and default width constants for D_WIDTH and A_WIDTH.
- Sub-module ram_rd_fifo: synchronous FIFO, depth FIFO_DEPTH, width D_WIDTH+1 (data plus last).
  - Registered head; exposes count, valid/ready on both sides.
- The top level holds the FSM, address/issue counter and 2-stage inflight valid pipe.

Test Plan:
- Burst, base=3, len=4, mem[i]=16'hA000+i, m_ready=1 -> beats A003..A006 on consecutive cycles; first m_valid 2 cycles after start; m_last on A006; done 1 cycle after the last handshake.
- Wrap: base=30, len=4 (A_WIDTH=5) -> address_read sequence 30,31,0,1; data mem[30],mem[31],mem[0],mem[1].
- Backpressure: len=8, m_ready toggled 0/1 every cycle and held 0 for 10 cycles mid-burst -> all 8 beats in order, none lost or duplicated; data stable during stalls; issue halts once fifo_count+inflight reaches 4.
- len=0 -> no handshakes; done pulses the next cycle; busy stays 0. start asserted while busy on another burst -> ignored; burst output unchanged.
- Reset mid-burst: rst_n low after 2 beats of a len=8 burst -> outputs 0 immediately (asynchronously); no done. A new start with len=2 after release returns the correct 2 beats.
- With RAM_READER_PERF_EN: len=4, m_ready=0 for 5 cycles while m_valid=1 -> stall_cycles=5 at done.
